// File: rtl/intt_pair_sequencer.sv
// intt_pair_sequencer: captures one DEPTH-word coefficient block over a valid/ready
// stream, then replays it as 2**LOOP_W registered (a, b) butterfly-partner pairs with
// the data_loop index consumed by the INTT switch stage. Requires DEPTH >= 2.
module intt_pair_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned LOOP_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [LOOP_W-1:0] data_loop,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       AddrW    = $clog2(DEPTH);
  localparam int unsigned       LastBeat = (2 ** LOOP_W) - 1;
  localparam logic [AddrW-1:0]  LastWord = AddrW'(DEPTH - 1);
  // Partner offset: flipping the top address bit pairs word k with word k + DEPTH/2.
  localparam logic [AddrW-1:0]  HalfIdx  = AddrW'(DEPTH / 2);

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

  state_e              state_q, state_d;
  logic [AddrW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [LOOP_W-1:0]   beat_q, beat_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                accept;
  logic [AddrW-1:0]    rd_a_idx;
  logic [AddrW-1:0]    rd_b_idx;

  assign accept = (state_q == StLoad) && in_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start only matters in idle; stream length is fixed, no backpressure.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StLoad;
      StLoad:   if (accept && (wr_cnt_q == LastWord)) state_d = StStream;
      StStream: if (beat_q == LOOP_W'(LastBeat)) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    in_ready  = (state_q == StLoad);
    out_valid = (state_q == StStream);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
  end

  // Write pointer and beat counter; beat_q stays zero outside the stream so data_loop
  // reads as a clean zero whenever out_valid is low.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (state_q == StIdle) begin
      wr_cnt_d = '0;
    end else if (accept) begin
      wr_cnt_d = wr_cnt_q + AddrW'(1);
    end
    beat_d = '0;
    if ((state_q == StStream) && (state_d == StStream)) begin
      beat_d = beat_q + LOOP_W'(1);
    end
  end

  assign rd_a_idx = beat_d[AddrW-1:0];
  assign rd_b_idx = rd_a_idx ^ HalfIdx;

  // Pair fetch for the beat about to be presented; the word being written on this
  // same edge is forwarded from in_data so beat 0 never sees a stale entry.
  always_comb begin
    a_d = '0;
    b_d = '0;
    if (state_d == StStream) begin
      a_d = (accept && (rd_a_idx == wr_cnt_q)) ? in_data : mem_q[rd_a_idx];
      b_d = (accept && (rd_b_idx == wr_cnt_q)) ? in_data : mem_q[rd_b_idx];
    end
  end

  // Counters and output pair registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      beat_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      beat_q   <= beat_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  // Coefficient buffer; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_cnt_q] <= in_data;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign data_loop = beat_q;

endmodule

// File: tb/tb_intt_pair_sequencer.sv
// Bench for intt_pair_sequencer: behavioural model checked every cycle plus
// directed scenarios with literal expectations.
module tb_intt_pair_sequencer;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int LW    = 6;
  localparam int NB    = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [LW-1:0] data_loop;
  logic          out_valid;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  intt_pair_sequencer #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .LOOP_W (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .data_loop (data_loop),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model: block buffer, load progress, and which beat is showing.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_load = 1'b0;
  bit            m_done = 1'b0;
  int            m_wr   = 0;
  int            m_beat = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load <= 1'b0;
      m_done <= 1'b0;
      m_wr   <= 0;
      m_beat <= -1;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_beat >= 0) begin
      if (m_beat == NB - 1) begin
        m_beat <= -1;
        m_done <= 1'b1;
      end else begin
        m_beat <= m_beat + 1;
      end
    end else if (m_load) begin
      if (in_valid) begin
        m_mem[m_wr] <= in_data;
        m_wr        <= m_wr + 1;
        if (m_wr == DEPTH - 1) begin
          m_load <= 1'b0;
          m_beat <= 0;
        end
      end
    end else if (start) begin
      m_load <= 1'b1;
      m_wr   <= 0;
    end
  end

  function automatic logic [41:0] model_vec();
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic [LW-1:0] el;
    ea = '0;
    eb = '0;
    el = '0;
    if (m_beat >= 0) begin
      el = LW'(m_beat);
      ea = m_mem[m_beat % DEPTH];
      eb = m_mem[(m_beat % DEPTH) ^ (DEPTH / 2)];
    end
    return {m_load, (m_beat >= 0), (m_load || (m_beat >= 0) || m_done), m_done, el, ea, eb};
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("cycle", 64'({in_ready, out_valid, busy, done, data_loop, a, b}), 64'(model_vec()));
  end

  // Capture of the streamed pairs by beat index.
  logic [DW-1:0] cap_a [NB];
  logic [DW-1:0] cap_b [NB];
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      cap_a[data_loop] <= a;
      cap_b[data_loop] <= b;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_block(input int base, input bit gaps, input bit zeros);
    int n;
    int guard;
    bit acc;
    n = 0;
    guard = 0;
    while (n < DEPTH && guard < 4 * DEPTH) begin
      in_valid = !(gaps && (guard % 2 == 1));
      in_data  = zeros ? '0 : DW'(base + n);
      if (gaps) chk("in_ready_during_load", 64'(in_ready), 64'd1);
      acc = in_valid && in_ready;
      tick();
      guard++;
      if (acc) n++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    chk("words_loaded", 64'(n), 64'(DEPTH));
    chk("first_beat_latency", 64'({out_valid, data_loop}), 64'd64);
  endtask

  task automatic run_stream(input bit poke);
    int n;
    n = 0;
    while (out_valid === 1'b1 && n < NB + 4) begin
      chk("beat_index", 64'(data_loop), 64'(n));
      start = poke && (n == 20);
      tick();
      n++;
    end
    start = 1'b0;
    chk("valid_cycles", 64'(n), 64'(NB));
    chk("done_pulse", 64'({done, busy, out_valid}), 64'(3'b110));
    start = poke;
    tick();
    start = 1'b0;
    chk("idle_after_done", 64'({done, busy, in_ready}), 64'(3'b000));
    repeat (3) tick();
    chk("no_restart", 64'({busy, in_ready}), 64'(2'b00));
  endtask

  task automatic check_lits(input int base);
    chk("beat0_a",  64'(cap_a[0]),  64'(base));
    chk("beat0_b",  64'(cap_b[0]),  64'(base + 16));
    chk("beat17_a", 64'(cap_a[17]), 64'(base + 17));
    chk("beat17_b", 64'(cap_b[17]), 64'(base + 1));
    chk("beat63_a", 64'(cap_a[63]), 64'(base + 31));
    chk("beat63_b", 64'(cap_b[63]), 64'(base + 15));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    int nz;
    rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_outputs", 64'({in_ready, out_valid, busy, done, data_loop, a, b}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back load of 100+i.
    do_start();
    load_block(100, 1'b0, 1'b0);
    run_stream(1'b0);
    check_lits(100);

    // Same data with in_valid gaps.
    do_start();
    load_block(100, 1'b1, 1'b0);
    run_stream(1'b0);
    check_lits(100);

    // start pulses during stream and in the done cycle are ignored.
    do_start();
    load_block(300, 1'b0, 1'b0);
    run_stream(1'b1);
    check_lits(300);

    // Asynchronous reset at beat 10, then a fresh block.
    do_start();
    load_block(400, 1'b0, 1'b0);
    g = 0;
    while (data_loop !== LW'(10) && g < NB) begin
      tick();
      g++;
    end
    chk("reached_beat10", 64'(data_loop), 64'd10);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 64'({in_ready, out_valid, busy, done, data_loop, a, b}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    load_block(200, 1'b0, 1'b0);
    run_stream(1'b0);
    check_lits(200);

    // in_valid while idle is dropped; a block of zeros streams as zeros.
    in_valid = 1'b1;
    in_data  = '1;
    repeat (4) tick();
    chk("idle_ignores_valid", 64'({busy, in_ready}), 64'd0);
    in_valid = 1'b0;
    in_data  = '0;
    do_start();
    load_block(0, 1'b0, 1'b1);
    run_stream(1'b0);
    nz = 0;
    for (int k = 0; k < NB; k++) begin
      if (cap_a[k] !== '0 || cap_b[k] !== '0) nz++;
    end
    chk("zero_block", 64'(nz), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
